// File: rtl/shift_reg_sequencer_if.sv
// shift_reg_sequencer_if: command channel and register control/status bundle for the shift-register sequencer
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3,
    parameter int CAP_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             sr_enb;
    logic             sr_dir;
    logic [1:0]       sr_modo;
    logic [WIDTH-1:0] sr_d;
    logic             sr_s_in;
    logic             sr_s_out;
    logic             busy;
    logic             done;
    logic [CAP_W-1:0] cap_data;

    // host side: issues commands and hosts the controlled register
    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_count, cmd_data, sr_s_out,
        input  cmd_ready, sr_enb, sr_dir, sr_modo, sr_d, sr_s_in, busy, done, cap_data
    );

    // sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_count, cmd_data, sr_s_out,
        output cmd_ready, sr_enb, sr_dir, sr_modo, sr_d, sr_s_in, busy, done, cap_data
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: command-driven Moore controller for a 4-bit shifting register; optional abort via SHIFT_SEQ_ABORT_EN
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3,
    parameter int CAP_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    shift_reg_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_dir;
    logic             r_sin;
    logic [1:0]       r_modo;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CAP_W-1:0] r_cap;
    logic             w_acc;
    logic             w_abort;

    assign w_acc = bus.cmd_valid && bus.cmd_ready;

`ifdef SHIFT_SEQ_ABORT_EN
    logic r_aborted;
    assign w_abort = abort && (r_state == RUN || r_state == LOAD);
    assign aborted = r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    // next-state decode; a zero-length shift/rotate completes like a nop
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = !w_acc ? IDLE
                         : bus.cmd_op == 2'b00 ? LOAD
                         : (bus.cmd_op != 2'b11 && bus.cmd_count != '0) ? RUN : DONE;
            LOAD: w_next = DONE;
            RUN:  w_next = (w_abort || r_cnt == CNT_W'(1)) ? DONE : RUN;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state, latched command fields, step counter and serial capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_dir   <= 1'b0;
            r_sin   <= 1'b0;
            r_modo  <= 2'b00;
            r_d     <= '0;
            r_cnt   <= '0;
            r_cap   <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_dir <= bus.cmd_dir;
                r_sin <= bus.cmd_data[0];
                r_cnt <= bus.cmd_count;
                if (bus.cmd_op == 2'b00) begin
                    r_modo <= 2'b10;
                    r_d    <= bus.cmd_data;
                end else if (w_next == RUN) begin
                    r_modo <= {1'b0, bus.cmd_op == 2'b10};
                    r_cap  <= '0;
                end
            end
            if (r_state == RUN) begin
                r_cap <= {r_cap[CAP_W-2:0], bus.sr_s_out};
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

`ifdef SHIFT_SEQ_ABORT_EN
    // aborted accompanies the done pulse of an aborted command only
    always_ff @(posedge CLK) begin
        if (RST) r_aborted <= 1'b0;
        else     r_aborted <= w_abort;
    end
`endif

    assign bus.cmd_ready = r_state == IDLE && !RST;
    assign bus.sr_enb    = !(r_state == LOAD || r_state == RUN);
    assign bus.sr_dir    = r_dir;
    assign bus.sr_modo   = r_modo;
    assign bus.sr_d      = r_d;
    assign bus.sr_s_in   = r_state == RUN && r_sin;
    assign bus.busy      = r_state != IDLE;
    assign bus.done      = r_state == DONE;
    assign bus.cap_data  = r_cap;
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: directed bench for shift_reg_sequencer driving a behavioural 4-bit shifting register
module tb_shift_reg_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_at;
    int   enb_n;
    int   pulses;
    logic [1:0] modo_l;
    logic [3:0] d_l;
    logic [3:0] q = 4'b0000;

    shift_reg_sequencer_if #(.WIDTH(4), .CNT_W(3), .CAP_W(8)) io ();

`ifdef SHIFT_SEQ_ABORT_EN
    logic abort = 1'b0;
    logic aborted;
    shift_reg_sequencer dut (.CLK(clk), .RST(rst), .abort(abort), .aborted(aborted), .bus(io));
`else
    shift_reg_sequencer dut (.CLK(clk), .RST(rst), .bus(io));
`endif

    always #5 clk = ~clk;

    // behavioural model of the controlled register
    always @(posedge clk) begin
        if (!io.sr_enb) begin
            case (io.sr_modo)
                2'b10:   q <= io.sr_d;
                2'b00:   q <= io.sr_dir ? {io.sr_s_in, q[3:1]} : {q[2:0], io.sr_s_in};
                2'b01:   q <= io.sr_dir ? {q[0], q[3:1]} : {q[2:0], q[3]};
                default: q <= q;
            endcase
        end
    end
    assign io.sr_s_out = io.sr_dir ? q[0] : q[3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // issue one command at a negedge with ready high, then track enabled cycles and the done pulse
    task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [2:0] cnt, input logic [3:0] data);
        int n;
        n = 0;
        while (!io.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 20), 1);
        io.cmd_op    = op;
        io.cmd_dir   = dir;
        io.cmd_count = cnt;
        io.cmd_data  = data;
        io.cmd_valid = 1'b1;
        done_at = 0;
        enb_n   = 0;
        for (int k = 1; k <= 12 && done_at == 0; k++) begin
            @(negedge clk);
            if (k == 1) io.cmd_valid = 1'b0;
            if (!io.sr_enb) begin
                enb_n++;
                modo_l = io.sr_modo;
                d_l    = io.sr_d;
            end
            if (io.done) done_at = k;
        end
        @(negedge clk);
        check("done_single", 32'(io.done), 0);
    endtask

    initial begin
        io.cmd_valid = 1'b0;
        io.cmd_op    = 2'b11;
        io.cmd_dir   = 1'b0;
        io.cmd_count = 3'd0;
        io.cmd_data  = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_enb", 32'(io.sr_enb), 1);
        check("rst_done", 32'(io.done), 0);
        check("rst_busy", 32'(io.busy), 0);
        check("rst_cap", 32'(io.cap_data), 0);
        check("rst_ready", 32'(io.cmd_ready), 0);
        check("rst_modo", 32'(io.sr_modo), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(io.cmd_ready), 1);

        run_cmd(2'b00, 1'b0, 3'd0, 4'b1011);
        check("load_enb_cycles", 32'(enb_n), 1);
        check("load_modo", 32'(modo_l), 32'b10);
        check("load_d", 32'(d_l), 32'b1011);
        check("load_done_lat", 32'(done_at), 2);
        check("load_q", 32'(q), 32'b1011);

        run_cmd(2'b01, 1'b1, 3'd3, 4'b0000);
        check("shr_enb_cycles", 32'(enb_n), 3);
        check("shr_modo", 32'(modo_l), 0);
        check("shr_done_lat", 32'(done_at), 4);
        check("shr_q", 32'(q), 32'b0001);
        check("shr_cap", 32'(io.cap_data), 32'b00000110);

        run_cmd(2'b00, 1'b0, 3'd0, 4'b1000);
        run_cmd(2'b10, 1'b0, 3'd4, 4'b0000);
        check("rol_enb_cycles", 32'(enb_n), 4);
        check("rol_modo", 32'(modo_l), 1);
        check("rol_done_lat", 32'(done_at), 5);
        check("rol_q", 32'(q), 32'b1000);
        check("rol_cap", 32'(io.cap_data), 32'b00001000);

        run_cmd(2'b01, 1'b1, 3'd0, 4'b0001);
        check("cnt0_enb_cycles", 32'(enb_n), 0);
        check("cnt0_done_lat", 32'(done_at), 1);
        check("cnt0_q", 32'(q), 32'b1000);

        run_cmd(2'b11, 1'b1, 3'd5, 4'b0001);
        check("nop_enb_cycles", 32'(enb_n), 0);
        check("nop_done_lat", 32'(done_at), 1);
        check("nop_q", 32'(q), 32'b1000);

        // valid held high through a load; the follow-up shift is taken once, only in IDLE
        io.cmd_op = 2'b00; io.cmd_dir = 1'b0; io.cmd_count = 3'd0; io.cmd_data = 4'b0110;
        io.cmd_valid = 1'b1;
        pulses = 0;
        @(negedge clk);
        check("held_ready_load", 32'(io.cmd_ready), 0);
        io.cmd_op = 2'b01; io.cmd_dir = 1'b1; io.cmd_count = 3'd2; io.cmd_data = 4'b0001;
        @(negedge clk);
        pulses += int'(io.done);
        check("held_ready_done", 32'(io.cmd_ready), 0);
        @(negedge clk);
        check("held_ready_idle", 32'(io.cmd_ready), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) io.cmd_valid = 1'b0;
            pulses += int'(io.done);
        end
        check("held_done_count", 32'(pulses), 2);
        check("held_q", 32'(q), 32'b1101);
        check("held_cap", 32'(io.cap_data), 32'b00000001);
        check("held_idle", 32'(io.busy), 0);

        // reset during step 2 of a 5-step shift
        io.cmd_op = 2'b01; io.cmd_dir = 1'b0; io.cmd_count = 3'd5; io.cmd_data = 4'b0000;
        io.cmd_valid = 1'b1;
        @(negedge clk);
        io.cmd_valid = 1'b0;
        @(negedge clk);
        check("midrst_running", 32'(io.sr_enb), 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(io.busy), 0);
        check("midrst_enb", 32'(io.sr_enb), 1);
        check("midrst_cap", 32'(io.cap_data), 0);
        rst = 1'b0;
        pulses = int'(io.done);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pulses += int'(io.done);
        end
        check("midrst_no_done", 32'(pulses), 0);
        check("midrst_ready", 32'(io.cmd_ready), 1);

`ifdef SHIFT_SEQ_ABORT_EN
        run_cmd(2'b00, 1'b0, 3'd0, 4'b1010);
        io.cmd_op = 2'b01; io.cmd_dir = 1'b0; io.cmd_count = 3'd5; io.cmd_data = 4'b0000;
        io.cmd_valid = 1'b1;
        @(negedge clk);
        io.cmd_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_done", 32'(io.done), 1);
        check("abort_flag", 32'(aborted), 1);
        check("abort_enb", 32'(io.sr_enb), 1);
        check("abort_cap", 32'(io.cap_data), 32'b00000010);
        @(negedge clk);
        check("abort_flag_clear", 32'(aborted), 0);
        check("abort_idle", 32'(io.busy), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
